fft_bram_sched: RTL and testbench

//  Sequencer for a 64-point in-place radix-2 FFT over two 64x32 dual-port

---
 rtl/fft_bram_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_fft_bram_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bram_sched.sv
// Address and write-enable sequencer for a 64-point in-place radix-2 FFT over two
// ping-pong dual-port BRAM banks: bit-reversed load, 6 stages, natural-order unload.
module fft_bram_sched #(
    parameter int BFLY_LAT = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic       Out_Last,
    output logic       Busy,
    output logic       Done,
    output logic       Rd_Bank,
    output logic [2:0] Stage,
    output logic       Bf_Valid,
    output logic [4:0] Tw_Addr,
    output logic       Bk0_We_A,
    output logic       Bk0_We_B,
    output logic       Bk1_We_A,
    output logic       Bk1_We_B,
    output logic [5:0] Bk0_Addr_A,
    output logic [5:0] Bk0_Addr_B,
    output logic [5:0] Bk1_Addr_A,
    output logic [5:0] Bk1_Addr_B
);

    localparam int DL        = 1 + BFLY_LAT;
    localparam int STAGE_CYC = 32 + DL;
    localparam int CW        = $clog2(STAGE_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_UNLOAD
    } state_t;

    state_t        state_reg;
    logic [5:0]    cnt_reg;
    logic [CW-1:0] cyc_reg;
    logic [2:0]    stage_reg;
    logic          out_valid_reg;
    logic          done_reg;
    logic [4:0]    tw_reg;
    logic          dl_valid_reg [DL];
    logic [5:0]    dl_a_reg     [DL];
    logic [5:0]    dl_b_reg     [DL];

    logic          issue;
    logic [5:0]    k6;
    logic [5:0]    span;
    logic [5:0]    pos;
    logic [5:0]    iss_a;
    logic [5:0]    iss_b;
    logic [4:0]    iss_tw;
    logic [5:0]    rd_a;
    logic [5:0]    rd_b;
    logic          wr_en;
    logic [5:0]    wr_a;
    logic [5:0]    wr_b;
    logic [5:0]    load_addr;

    // Load counter read out bit-reversed gives the in-place FFT input ordering.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_brev
            assign load_addr[gi] = cnt_reg[5 - gi];
        end
    endgenerate

    // Butterfly pair k of stage s: insert a zero bit at position s to get a.
    always_comb begin
        issue  = (state_reg == S_COMPUTE) && (cyc_reg < CW'(32));
        k6     = {1'b0, cyc_reg[4:0]};
        span   = 6'd1 << stage_reg;
        pos    = k6 & (span - 6'd1);
        iss_a  = ((k6 >> stage_reg) << (stage_reg + 3'd1)) | pos;
        iss_b  = iss_a + span;
        iss_tw = pos[4:0] << (3'd5 - stage_reg);
        rd_a   = issue ? iss_a : 6'd0;
        rd_b   = issue ? iss_b : 6'd0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            cyc_reg       <= '0;
            stage_reg     <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (Start) begin
                        state_reg <= S_LOAD;
                        cnt_reg   <= '0;
                    end
                end
                S_LOAD: begin
                    if (In_Valid) begin
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'd63) begin
                            state_reg <= S_COMPUTE;
                            cyc_reg   <= '0;
                            stage_reg <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    // A stage ends only once its last write has left the delay line.
                    if (cyc_reg == CW'(STAGE_CYC - 1)) begin
                        cyc_reg <= '0;
                        if (stage_reg == 3'd5) begin
                            state_reg     <= S_UNLOAD;
                            stage_reg     <= '0;
                            cnt_reg       <= '0;
                            out_valid_reg <= 1'b0;
                        end else begin
                            stage_reg <= stage_reg + 3'd1;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (Out_Ready) begin
                        if (cnt_reg == 6'd63) begin
                            state_reg     <= S_IDLE;
                            out_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            cnt_reg       <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Read address and valid travel 1+BFLY_LAT cycles to become the write-back.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DL; i++) begin
                dl_valid_reg[i] <= 1'b0;
                dl_a_reg[i]     <= '0;
                dl_b_reg[i]     <= '0;
            end
            tw_reg <= '0;
        end else begin
            dl_valid_reg[0] <= issue;
            dl_a_reg[0]     <= rd_a;
            dl_b_reg[0]     <= rd_b;
            for (int i = 1; i < DL; i++) begin
                dl_valid_reg[i] <= dl_valid_reg[i - 1];
                dl_a_reg[i]     <= dl_a_reg[i - 1];
                dl_b_reg[i]     <= dl_b_reg[i - 1];
            end
            tw_reg <= issue ? iss_tw : 5'd0;
        end
    end

    always_comb begin
        wr_en = dl_valid_reg[DL - 1];
        wr_a  = wr_en ? dl_a_reg[DL - 1] : 6'd0;
        wr_b  = wr_en ? dl_b_reg[DL - 1] : 6'd0;
    end

    always_comb begin
        Bk0_We_A   = 1'b0;
        Bk0_We_B   = 1'b0;
        Bk1_We_A   = 1'b0;
        Bk1_We_B   = 1'b0;
        Bk0_Addr_A = 6'd0;
        Bk0_Addr_B = 6'd0;
        Bk1_Addr_A = 6'd0;
        Bk1_Addr_B = 6'd0;
        case (state_reg)
            S_LOAD: begin
                Bk0_We_A   = In_Valid;
                Bk0_Addr_A = load_addr;
            end
            S_COMPUTE: begin
                if (stage_reg[0]) begin
                    Bk1_Addr_A = rd_a;
                    Bk1_Addr_B = rd_b;
                    Bk0_We_A   = wr_en;
                    Bk0_We_B   = wr_en;
                    Bk0_Addr_A = wr_a;
                    Bk0_Addr_B = wr_b;
                end else begin
                    Bk0_Addr_A = rd_a;
                    Bk0_Addr_B = rd_b;
                    Bk1_We_A   = wr_en;
                    Bk1_We_B   = wr_en;
                    Bk1_Addr_A = wr_a;
                    Bk1_Addr_B = wr_b;
                end
            end
            S_UNLOAD: begin
                // Present the next index on acceptance so DO_B follows without a bubble.
                Bk0_Addr_B = (out_valid_reg && Out_Ready) ? cnt_reg + 6'd1 : cnt_reg;
            end
            default: ;
        endcase
    end

    assign Busy      = (state_reg != S_IDLE);
    assign In_Ready  = (state_reg == S_LOAD);
    assign Out_Valid = out_valid_reg;
    assign Out_Last  = out_valid_reg && (cnt_reg == 6'd63);
    assign Done      = done_reg;
    assign Stage     = stage_reg;
    assign Rd_Bank   = stage_reg[0];
    assign Bf_Valid  = dl_valid_reg[0];
    assign Tw_Addr   = tw_reg;

endmodule

// File: tb/tb_fft_bram_sched.sv
// Bench for fft_bram_sched: cycle-level frame model plus a bank0 tag memory
// that follows the DUT's writes, checked against the DUT on every falling edge.
module tb_fft_bram_sched;

    localparam int LAT = 3;
    localparam int SL  = 32 + 1 + LAT;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic       In_Valid;
    logic       In_Ready;
    logic       Out_Valid;
    logic       Out_Ready;
    logic       Out_Last;
    logic       Busy;
    logic       Done;
    logic       Rd_Bank;
    logic [2:0] Stage;
    logic       Bf_Valid;
    logic [4:0] Tw_Addr;
    logic       Bk0_We_A, Bk0_We_B, Bk1_We_A, Bk1_We_B;
    logic [5:0] Bk0_Addr_A, Bk0_Addr_B, Bk1_Addr_A, Bk1_Addr_B;

    fft_bram_sched #(.BFLY_LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Last(Out_Last), .Busy(Busy),
        .Done(Done), .Rd_Bank(Rd_Bank), .Stage(Stage), .Bf_Valid(Bf_Valid), .Tw_Addr(Tw_Addr),
        .Bk0_We_A(Bk0_We_A), .Bk0_We_B(Bk0_We_B), .Bk1_We_A(Bk1_We_A), .Bk1_We_B(Bk1_We_B),
        .Bk0_Addr_A(Bk0_Addr_A), .Bk0_Addr_B(Bk0_Addr_B),
        .Bk1_Addr_A(Bk1_Addr_A), .Bk1_Addr_B(Bk1_Addr_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 idle, 1 load, 2 compute, 3 unload.
    int   m_mode = 0, m_n = 0, m_t = 0, m_j = 0;
    bit   m_ov = 0, m_done = 0, m_valid = 0, prev_rst = 0;
    int   beat_cnt = 0, wtag = 0;
    logic [31:0] mem0 [64];
    logic [31:0] do_b;
    logic [31:0] new_do;

    int s, c, rb, wb, k, e_stage, e_tw;
    int ew [4];
    int ea [4];
    bit e_bfv, e_ov, e_last, e_busy, e_ir, e_rb, nd;
    logic [15:0] got_ctrl, exp_ctrl;
    logic [27:0] got_bank, exp_bank;

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < 6; i++) if (((v >> i) & 1) != 0) r = r + (1 << (5 - i));
        return r;
    endfunction

    function automatic int pa(input int st, input int kk);
        int sp = 1 << st;
        return (kk / sp) * 2 * sp + (kk % sp);
    endfunction

    function automatic int ptw(input int st, input int kk);
        return (kk % (1 << st)) * (32 >> st);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (m_valid) begin
            e_busy = (m_mode != 0); e_ir = (m_mode == 1);
            e_ov = 0; e_last = 0; e_bfv = 0; e_tw = 0; e_stage = 0; e_rb = 0;
            for (int i = 0; i < 4; i++) begin ew[i] = 0; ea[i] = 0; end
            case (m_mode)
                1: begin ew[0] = In_Valid ? 1 : 0; ea[0] = brev(m_n); end
                2: begin
                    s = m_t / SL; c = m_t % SL; rb = s % 2; wb = 1 - rb;
                    e_stage = s; e_rb = (rb == 1);
                    if (c < 32) begin ea[rb*2] = pa(s, c); ea[rb*2+1] = pa(s, c) + (1 << s); end
                    if (c >= 1 && c <= 32) begin e_bfv = 1; e_tw = ptw(s, c - 1); end
                    if (c >= 1 + LAT) begin
                        k = c - 1 - LAT;
                        ew[wb*2] = 1; ew[wb*2+1] = 1;
                        ea[wb*2] = pa(s, k); ea[wb*2+1] = pa(s, k) + (1 << s);
                    end
                end
                3: begin
                    e_ov = m_ov; e_last = m_ov && (m_j == 63);
                    ea[1] = (m_ov && Out_Ready) ? (m_j + 1) % 64 : m_j;
                end
                default: ;
            endcase
            got_ctrl = {Busy, In_Ready, Out_Valid, Out_Last, Done, Rd_Bank, Stage, Bf_Valid, Tw_Addr};
            exp_ctrl = {e_busy, e_ir, e_ov, e_last, m_done, e_rb, 3'(e_stage), e_bfv, 5'(e_tw)};
            got_bank = {Bk0_We_A, Bk0_We_B, Bk1_We_A, Bk1_We_B, Bk0_Addr_A, Bk0_Addr_B, Bk1_Addr_A, Bk1_Addr_B};
            exp_bank = {ew[0] != 0, ew[1] != 0, ew[2] != 0, ew[3] != 0,
                        6'(ea[0]), 6'(ea[1]), 6'(ea[2]), 6'(ea[3])};
            chk("ctrl", 64'(got_ctrl), 64'(exp_ctrl));
            chk("bank", 64'(got_bank), 64'(exp_bank));

            // Hand-derived pins: stage 2, k=5 -> a=9, b=13, tw=8; last stage-5 write at 31/63.
            if (m_mode == 1 && m_n == 1 && In_Valid) chk("load_brev1", 64'(Bk0_Addr_A), 64'd32);
            if (m_mode == 2 && m_t == 2*SL + 5) chk("s2k5_rd", 64'({Bk0_Addr_A, Bk0_Addr_B}), 64'({6'd9, 6'd13}));
            if (m_mode == 2 && m_t == 2*SL + 6) chk("s2k5_tw", 64'({Bf_Valid, Tw_Addr}), 64'({1'b1, 5'd8}));
            if (m_mode == 2 && m_t == 2*SL + 5 + 1 + LAT)
                chk("s2k5_wr", 64'({Bk1_We_A, Bk1_We_B, Bk1_Addr_A, Bk1_Addr_B}), 64'({2'b11, 6'd9, 6'd13}));
            if (m_mode == 2 && m_t == 6*SL - 1)
                chk("last_wr", 64'({Stage, Bk0_We_A, Bk0_Addr_A, Bk0_Addr_B}), 64'({3'd5, 1'b1, 6'd31, 6'd63}));
            if (prev_rst)
                chk("post_rst", 64'({Busy, Bk0_We_A, Bk0_We_B, Bk1_We_A, Bk1_We_B, Bf_Valid, Out_Valid}), 64'd0);

            if (Out_Valid && Out_Ready && !Rst) begin
                chk("unload_data", 64'(do_b), 64'(mem0[beat_cnt % 64]));
                chk("unload_last", 64'(Out_Last), 64'(beat_cnt == 63));
                beat_cnt++;
            end
            if (Done) begin
                chk("frame_beats", 64'(beat_cnt), 64'd64);
                beat_cnt = 0;
            end
        end

        // Bank0 tag memory, read-first port B with one cycle of read latency.
        new_do = mem0[Bk0_Addr_B];
        if (Bk0_We_A) begin wtag++; mem0[Bk0_Addr_A] = 32'(wtag); end
        if (Bk0_We_B) begin wtag++; mem0[Bk0_Addr_B] = 32'(wtag); end
        do_b = new_do;

        nd = 0;
        if (Rst) begin
            m_mode = 0; m_ov = 0; beat_cnt = 0; m_valid = 1;
        end else begin
            case (m_mode)
                0: if (Start) begin m_mode = 1; m_n = 0; end
                1: if (In_Valid) begin
                        m_n++;
                        if (m_n == 64) begin m_mode = 2; m_t = 0; end
                    end
                2: begin
                        m_t++;
                        if (m_t == 6*SL) begin m_mode = 3; m_j = 0; m_ov = 0; end
                    end
                3: if (!m_ov) m_ov = 1;
                   else if (Out_Ready) begin
                        if (m_j == 63) begin m_mode = 0; m_ov = 0; nd = 1; end
                        else m_j++;
                   end
                default: m_mode = 0;
            endcase
        end
        m_done = nd;
        prev_rst = Rst;
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            In_Valid  = 1'($urandom_range(0, 1));
            Out_Ready = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0; Out_Ready = 1'b0;
    endtask

    // iv_mode 0: In_Valid held, 1: random. or_mode 0: held, 1: random, 2: toggling.
    task automatic run_frame(input int iv_mode, input int or_mode, input bit noise);
        int cyc = 0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        while (m_mode != 0 && cyc < 4000) begin
            In_Valid  = (iv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            Out_Ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
            Start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge Clk); #1;
            cyc++;
        end
        Start = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        if (cyc >= 4000) begin
            $display("FAIL frame_timeout: model still busy after %0d cycles", cyc);
            $fatal(1, "frame did not complete");
        end
    endtask

    initial begin
        int cyc;
        Rst = 1'b1; Start = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Rst = 1'b0;
        idle_cycles(6);

        run_frame(0, 0, 1'b0);
        idle_cycles(3);
        run_frame(1, 1, 1'b1);
        run_frame(0, 2, 1'b0);

        // Abort mid-compute in stage 3, then a clean frame.
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; In_Valid = 1'b1;
        cyc = 0;
        while (!(m_mode == 2 && m_t / SL == 3) && cyc < 2000) begin
            @(posedge Clk); #1;
            cyc++;
        end
        if (cyc >= 2000) begin
            $display("FAIL abort_wait: stage 3 not reached in %0d cycles", cyc);
            $fatal(1, "abort wait expired");
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; In_Valid = 1'b0;
        idle_cycles(3);
        run_frame(0, 0, 1'b0);
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
